// File: rtl/synchronous_fifo_status_if.sv
// synchronous_fifo_status_if: producer/consumer handshake bundle for the status FIFO
interface synchronous_fifo_status_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic rd_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [CW-1:0] count;
  logic err_clr;
  logic overflow;
  logic underflow;
  modport master (
    output w_en, data_in, r_en, err_clr,
    input data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input w_en, data_in, r_en, err_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/synchronous_fifo_status.sv
// synchronous_fifo_status: single-clock FIFO with count, almost flags, read-valid strobe and sticky errors
module synchronous_fifo_status #(
  parameter int DEPTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  synchronous_fifo_status_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic wr_acc, rd_acc;
  assign bus.count = cnt;
  assign bus.full = cnt == CW'(DEPTH);
  assign bus.empty = cnt == '0;
  assign bus.almost_full = cnt >= CW'(AF_TH);
  assign bus.almost_empty = cnt <= CW'(AE_TH);
  assign wr_acc = bus.w_en && !bus.full;
  assign rd_acc = bus.r_en && !bus.empty;
  always_ff @(posedge clk)
    if (rst_n && wr_acc) mem[wr_ptr] <= bus.data_in;
  // explicit compare keeps wrap correct for non-power-of-two depths
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? (wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1) : wr_ptr;
      rd_ptr <= rd_acc ? (rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
      bus.data_out <= rd_acc ? mem[rd_ptr] : bus.data_out;
      bus.rd_valid <= rd_acc;
      bus.overflow <= (bus.overflow && !bus.err_clr) || (bus.w_en && bus.full);
      bus.underflow <= (bus.underflow && !bus.err_clr) || (bus.r_en && bus.empty);
    end
endmodule

// File: tb/tb_synchronous_fifo_status.sv
// tb_synchronous_fifo_status: directed checks of the status FIFO at DEPTH=6, AF_TH=5, AE_TH=1
module tb_synchronous_fifo_status;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  synchronous_fifo_status_if #(.DATA_WIDTH(8), .DEPTH(6)) bus ();
  synchronous_fifo_status #(.DEPTH(6), .DATA_WIDTH(8), .AF_TH(5), .AE_TH(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic lvl(input string tag, input int c);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(c == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(c == 6));
    chk({tag, ".af"}, 32'(bus.almost_full), 32'(c >= 5));
    chk({tag, ".ae"}, 32'(bus.almost_empty), 32'(c <= 1));
  endtask
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    bus.w_en = w;
    bus.r_en = r;
    bus.data_in = d;
    bus.err_clr = c;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.err_clr = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [7:0] exp, input int c);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk({tag, ".data"}, 32'(bus.data_out), 32'(exp));
    chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
    lvl(tag, c);
  endtask
  initial begin
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.data_in = '0;
    bus.err_clr = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    lvl("reset", 0);
    chk("reset.data", 32'(bus.data_out), 32'h0);
    chk("reset.valid", 32'(bus.rd_valid), 32'h0);
    chk("reset.ovf", 32'(bus.overflow), 32'h0);
    chk("reset.unf", 32'(bus.underflow), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
      lvl($sformatf("fill%0d", i), i + 1);
    end
    for (int i = 0; i < 6; i++) rd($sformatf("drain%0d", i), 8'(8'h11 + i), 5 - i);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle.valid", 32'(bus.rd_valid), 32'h0);
    chk("idle.hold", 32'(bus.data_out), 32'h16);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
    for (int i = 0; i < 4; i++) rd($sformatf("pre%0d", i), 8'(8'h21 + i), 3 - i);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    lvl("wrapfull", 6);
    for (int i = 0; i < 6; i++) rd($sformatf("wrap%0d", i), 8'(8'hA0 + i), 5 - i);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h31 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("fullwr.data", 32'(bus.data_out), 32'h31);
    chk("fullwr.valid", 32'(bus.rd_valid), 32'h1);
    chk("fullwr.ovf", 32'(bus.overflow), 32'h1);
    lvl("fullwr", 5);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf.sticky", 32'(bus.overflow), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf.clr", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 5; i++) rd($sformatf("rest%0d", i), 8'(8'h32 + i), 4 - i);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    chk("emptyrw.valid", 32'(bus.rd_valid), 32'h0);
    chk("emptyrw.unf", 32'(bus.underflow), 32'h1);
    chk("emptyrw.hold", 32'(bus.data_out), 32'h36);
    lvl("emptyrw", 1);
    rd("emptyrw.rd", 8'h3C, 0);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("unf.setwins", 32'(bus.underflow), 32'h1);
    chk("unf.novalid", 32'(bus.rd_valid), 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf.clr", 32'(bus.underflow), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h41 + i), 1'b0);
    lvl("prerst", 3);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'h99, 1'b0);
    rst_n = 1'b1;
    lvl("midrst", 0);
    chk("midrst.data", 32'(bus.data_out), 32'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("postrst.unf", 32'(bus.underflow), 32'h1);
    chk("postrst.valid", 32'(bus.rd_valid), 32'h0);
    lvl("postrst", 0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    lvl("postrst.wr", 1);
    rd("postrst.rd", 8'h55, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo_status.md
Name: synchronous_fifo_status

Overview:
Parametrised next-generation single-clock FIFO, a drop-in successor to the basic synchronous FIFO. It keeps the same w_en/r_en/full/empty contract and adds:
- arbitrary (non-power-of-two) depth
- an occupancy count
- programmable almost-full and almost-empty thresholds
- a read-data-valid strobe
- sticky overflow/underflow error flags with a clear input

It sits between producer and consumer logic in the same clock domain and is driven by the team's FIFO interface in the layered bench.

Parameters:
DEPTH, 8, number of entries; any integer >= 2, power of two not required.
DATA_WIDTH, 8, width of each data word in bits.
AF_TH, 6, almost_full asserts when count >= AF_TH; legal range 1..DEPTH.
AE_TH, 2, almost_empty asserts when count <= AE_TH; legal range 0..DEPTH-1; AE_TH < AF_TH required.
CW, $clog2(DEPTH+1), derived count width; not to be overridden.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
w_en  input  1  write request.
data_in  input  DATA_WIDTH  write data, sampled with w_en.
r_en  input  1  read request.
data_out  output  DATA_WIDTH  registered read data.
rd_valid  output  1  one-cycle strobe: data_out updated by an accepted read.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_TH.
almost_empty  output  1  count <= AE_TH.
count  output  CW  current occupancy, 0..DEPTH.
err_clr  input  1  clears overflow/underflow.
overflow  output  1  sticky: write attempted while full.
underflow  output  1  sticky: read attempted while empty.

Behaviour:
- One clock; reset is synchronous and active-low. rst_n sampled low at a rising clk edge resets state; there is no asynchronous path.
- Reset values:
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
- Write accept: wr_acc = w_en && !full, evaluated on registered flags. The entry at wr_ptr gets data_in; wr_ptr advances.
- Read accept: rd_acc = r_en && !empty. data_out <= mem[rd_ptr]; rd_ptr advances; rd_valid = 1 in the following cycle only.
- Read latency: one cycle. data_out and rd_valid change at the same edge that consumes the entry. data_out holds its value when no read is accepted.
- Full with simultaneous w_en and r_en: only the read is accepted. The write is rejected and sets overflow.
- Empty with simultaneous w_en and r_en: only the write is accepted. The read is rejected and sets underflow. There is no fall-through.
- Neither full nor empty, both requested: both accepted, count unchanged.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise. Never exceeds DEPTH or goes below 0.
- Pointer wrap: each pointer runs 0..DEPTH-1 and returns to 0 after DEPTH-1. Wrap must not depend on a power-of-two DEPTH.
- Flags full, empty, almost_full, almost_empty are combinational decodes of the registered count. They reflect an accept from the next cycle onward.
- Error flags:
  - overflow sets on any cycle with w_en && full; underflow sets on any cycle with r_en && empty.
  - Both hold until err_clr = 1.
  - If set and clear occur in the same cycle, set wins.
  - Rejected accesses do not alter pointers, count or data_out.
- Reset mid-operation: all stored data is discarded (pointers and count to 0). A w_en/r_en asserted in the reset cycle is ignored. Normal operation resumes on the first edge with rst_n = 1.
- Data ordering: strict first-in first-out across any number of wraps.

Test Plan:
1. Reset, DEPTH=6, AF_TH=5, AE_TH=1: hold rst_n=0 for 2 cycles -> empty=1, full=0, count=0, almost_empty=1, data_out=0, overflow=underflow=0.
2. Write 0x11..0x16 on 6 consecutive cycles, then read 6 -> almost_full rises after the 5th write, full=1 and count=6 after the 6th. Reads return 0x11..0x16 in order with rd_valid high 1 cycle after each r_en. empty=1 at end.
3. Wrap: fill 4, read 4, write 0xA0..0xA5, read 6 -> output 0xA0..0xA5 in order; pointers wrapped past index 5 with no corruption.
4. At full (count=6), assert w_en=1, r_en=1 with data_in=0x77 -> oldest word read, 0x77 not stored, count=5, overflow=1. err_clr pulse -> overflow=0.
5. At empty, assert r_en=1, w_en=1 with data_in=0x3C -> no rd_valid, underflow=1, count=1. Next read returns 0x3C.
6. Write 3 words, assert rst_n=0 for 1 cycle together with w_en=1 -> count=0, empty=1. Subsequent read gives underflow=1 with no rd_valid; a new write then read returns the new data.
